// File: rtl/fp32_div_seq_if.sv
// fp32_div_seq_if: operand/result handshake bundle for the sequential fp32 divider.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

interface fp32_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

`default_nettype wire

// File: rtl/fp32_div_seq.sv
// fp32_div_seq: multi-cycle IEEE-754 fp32 divider, radix-2 restoring, round-to-nearest-even, flush-to-zero.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module fp32_div_seq #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC00001,
  parameter int          QBITS     = 26
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fp32_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_sign;
  logic [7:0]       r_ea;
  logic [7:0]       r_eb;
  logic [23:0]      r_mb;
  logic [24:0]      r_rem;
  logic [QBITS-1:0] r_q;
  logic [4:0]       r_count;
  logic [31:0]      r_result;
  logic [4:0]       r_flags;

  // ---------------- operand classification ----------------
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic        w_sign;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_in_ready;
  logic        w_accept;

  assign w_ea   = bus.a[30:23];
  assign w_eb   = bus.b[30:23];
  assign w_fa   = bus.a[22:0];
  assign w_fb   = bus.b[22:0];
  assign w_sign = bus.a[31] ^ bus.b[31];

  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  // Zero exponent covers denormals too: they are flushed to signed zero.
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);

  assign w_in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;

  logic        w_special;
  logic [31:0] w_sp_result;
  logic [4:0]  w_sp_flags;

  always_comb begin
    w_special   = 1'b1;
    w_sp_result = NAN_VALUE;
    w_sp_flags  = 5'b10000;
    if (w_a_nan || w_b_nan) begin
      w_sp_result = NAN_VALUE;
      w_sp_flags  = 5'b10000;
    end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_sp_result = NAN_VALUE;
      w_sp_flags  = 5'b10000;
    end else if (w_a_inf) begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
      w_sp_flags  = 5'b00000;
    end else if (w_b_inf) begin
      w_sp_result = {w_sign, 31'd0};
      w_sp_flags  = 5'b00000;
    end else if (w_b_zero) begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
      w_sp_flags  = 5'b01000;
    end else if (w_a_zero) begin
      w_sp_result = {w_sign, 31'd0};
      w_sp_flags  = 5'b00000;
    end else begin
      w_special   = 1'b0;
      w_sp_result = 32'd0;
      w_sp_flags  = 5'b00000;
    end
  end

  // ---------------- restoring divide step ----------------
  logic        w_ge;
  logic [24:0] w_diff;
  logic [24:0] w_sel;
  logic [24:0] w_rem_next;

  assign w_ge       = (r_rem >= {1'b0, r_mb});
  assign w_diff     = r_rem - {1'b0, r_mb};
  assign w_sel      = w_ge ? w_diff : r_rem;
  assign w_rem_next = w_sel << 1;

  // ---------------- normalise and round ----------------
  logic               w_hi;
  logic [23:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_inc;
  logic               w_inexact;
  logic [24:0]        w_mant_rnd;
  logic               w_carry;
  logic [22:0]        w_mant_fin;
  logic signed [9:0]  w_exp_base;
  logic signed [9:0]  w_exp_fin;
  logic [31:0]        w_rnd_result;
  logic [4:0]         w_rnd_flags;

  assign w_hi       = r_q[QBITS-1];
  assign w_mant     = w_hi ? r_q[QBITS-1:2] : r_q[QBITS-2:1];
  assign w_guard    = w_hi ? r_q[1] : r_q[0];
  assign w_sticky   = (w_hi && r_q[0]) || (r_rem != 25'd0);
  assign w_inexact  = w_guard || w_sticky;
  assign w_inc      = w_guard && (w_sticky || w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + {24'd0, w_inc};
  assign w_carry    = w_mant_rnd[24];
  assign w_mant_fin = w_carry ? w_mant_rnd[23:1] : w_mant_rnd[22:0];

  assign w_exp_base = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                    + (w_hi ? 10'sd127 : 10'sd126);
  assign w_exp_fin  = w_exp_base + $signed({9'd0, w_carry});

  always_comb begin
    w_rnd_result = {r_sign, w_exp_fin[7:0], w_mant_fin};
    w_rnd_flags  = {4'b0000, w_inexact};
    if (w_exp_fin >= 10'sd255) begin
      w_rnd_result = {r_sign, 8'hFF, 23'd0};
      w_rnd_flags  = 5'b00101;
    end else if (w_exp_fin <= 10'sd0) begin
      w_rnd_result = {r_sign, 31'd0};
      w_rnd_flags  = 5'b00011;
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_special ? S_DONE : S_DIV;
        end
      end
      S_DIV: begin
        if (r_count == 5'(QBITS - 1)) begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_ea     <= 8'd0;
      r_eb     <= 8'd0;
      r_mb     <= 24'd0;
      r_rem    <= 25'd0;
      r_q      <= '0;
      r_count  <= 5'd0;
      r_result <= 32'd0;
      r_flags  <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign  <= w_sign;
            r_ea    <= w_ea;
            r_eb    <= w_eb;
            r_mb    <= {1'b1, w_fb};
            r_rem   <= {2'b01, w_fa};
            r_q     <= '0;
            r_count <= 5'd0;
            if (w_special) begin
              r_result <= w_sp_result;
              r_flags  <= w_sp_flags;
            end
          end
        end
        S_DIV: begin
          r_rem   <= w_rem_next;
          r_q     <= {r_q[QBITS-2:0], w_ge};
          r_count <= r_count + 5'd1;
        end
        S_ROUND: begin
          r_result <= w_rnd_result;
          r_flags  <= w_rnd_flags;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_DIV) || (r_state == S_ROUND);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

`default_nettype wire
